// File: rtl/int_ack_sequencer_pkg.sv
// Shared types and constants for the interrupt-acknowledge sequencer and its IVT reader.
package int_ack_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK1,
    ST_GAP,
    ST_ACK2,
    ST_WAIT_VEC,
    ST_FETCH,
    ST_DONE
  } state_t;

  localparam logic [19:0] IVT_BASE    = 20'h00000;
  localparam int          INTA_PULSES = 2;

  // The byte index only ever occupies the two low bits, so there is no carry into the vector.
  function automatic logic [19:0] ivt_addr(input logic [7:0] vec, input logic [1:0] k);
    return IVT_BASE | {10'b0, vec, k};
  endfunction

endpackage

// File: rtl/int_ack_sequencer_ivt_byte_reader.sv
// Reads the four IVT bytes of one vector in order and assembles them into IP and CS.
module ivt_byte_reader
  import int_ack_sequencer_pkg::*;
(
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        start,
  input  logic [7:0]  vec,
  output logic        bus_rd,
  output logic [19:0] bus_addr,
  input  logic        bus_rdy,
  input  logic [7:0]  bus_data,
  output logic        done,
  output logic [15:0] ip,
  output logic [15:0] cs
);

  logic [1:0] k;
  logic [7:0] vec_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      k        <= 2'd0;
      vec_q    <= 8'h00;
      bus_rd   <= 1'b0;
      bus_addr <= 20'h00000;
      done     <= 1'b0;
      ip       <= 16'h0000;
      cs       <= 16'h0000;
    end else begin
      done <= 1'b0;
      if (start) begin
        vec_q    <= vec;
        k        <= 2'd0;
        bus_rd   <= 1'b1;
        bus_addr <= ivt_addr(vec, 2'd0);
      end else if (bus_rd && bus_rdy) begin
        case (k)
          2'd0: ip[7:0]  <= bus_data;
          2'd1: ip[15:8] <= bus_data;
          2'd2: cs[7:0]  <= bus_data;
          2'd3: cs[15:8] <= bus_data;
          default: ;
        endcase
        if (k == 2'd3) begin
          bus_rd <= 1'b0;
          done   <= 1'b1;
        end else begin
          k        <= k + 2'd1;
          bus_addr <= ivt_addr(vec_q, k + 2'd1);
        end
      end
    end
  end

endmodule

// File: rtl/int_ack_sequencer.sv
// CPU-side 8259 interrupt-acknowledge initiator: two INTA pulses, vector capture, IVT fetch.
module int_ack_sequencer
  import int_ack_sequencer_pkg::*;
#(
  parameter int         ACK_GAP      = 2,
  parameter int         SEL_TIMEOUT  = 15,
  parameter logic [7:0] SPURIOUS_VEC = 8'h0F
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iInt,
  input  logic        iIntEn,
  input  logic        iBoundary,
  output logic        oIntAck,
  input  logic        iSel,
  input  logic [7:0]  iData,
  output logic        oBusRd,
  output logic [19:0] oBusAddr,
  input  logic        iBusRdy,
  input  logic [7:0]  iBusData,
  output logic        oDone,
  output logic [7:0]  oVector,
  output logic [15:0] oIp,
  output logic [15:0] oCs,
  output logic        oSpurious,
  output logic        oBusy
);

  localparam int GAP_W = (ACK_GAP < 2) ? 1 : $clog2(ACK_GAP);
  localparam int TMO_W = (SEL_TIMEOUT < 2) ? 1 : $clog2(SEL_TIMEOUT);

  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              sel_hit;
  logic              tmo_hit;
  logic              rd_start;
  logic [7:0]        rd_vec;
  logic              rd_done;
  logic [15:0]       rd_ip;
  logic [15:0]       rd_cs;

  // The reader is launched on the same edge that leaves WAIT_VEC so the first read is not delayed.
  assign sel_hit  = (state == ST_WAIT_VEC) && iSel;
  assign tmo_hit  = (state == ST_WAIT_VEC) && !iSel && (tmo_cnt == TMO_W'(SEL_TIMEOUT - 1));
  assign rd_start = sel_hit || tmo_hit;
  assign rd_vec   = iSel ? iData : SPURIOUS_VEC;

  ivt_byte_reader u_reader (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .start    (rd_start),
    .vec      (rd_vec),
    .bus_rd   (oBusRd),
    .bus_addr (oBusAddr),
    .bus_rdy  (iBusRdy),
    .bus_data (iBusData),
    .done     (rd_done),
    .ip       (rd_ip),
    .cs       (rd_cs)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      oIntAck   <= 1'b0;
      oDone     <= 1'b0;
      oVector   <= 8'h00;
      oIp       <= 16'h0000;
      oCs       <= 16'h0000;
      oSpurious <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oIntAck   <= 1'b0;
      oDone     <= 1'b0;
      oSpurious <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iBoundary && iIntEn && iInt) begin
            state   <= ST_ACK1;
            oIntAck <= 1'b1;
            oBusy   <= 1'b1;
          end
        end
        ST_ACK1: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(ACK_GAP - 1)) begin
            state   <= ST_ACK2;
            oIntAck <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_ACK2: begin
          state   <= ST_WAIT_VEC;
          tmo_cnt <= '0;
        end
        ST_WAIT_VEC: begin
          if (sel_hit) begin
            oVector <= iData;
            state   <= ST_FETCH;
          end else if (tmo_hit) begin
            oVector   <= SPURIOUS_VEC;
            oSpurious <= 1'b1;
            state     <= ST_FETCH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          if (rd_done) begin
            oIp   <= rd_ip;
            oCs   <= rd_cs;
            oDone <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Randomized bench for int_ack_sequencer with a PIC/memory responder and a timeline reference model.
module tb_int_ack_sequencer;

  localparam int         ACK_GAP     = 2;
  localparam int         SEL_TIMEOUT = 15;
  localparam logic [7:0] SPUR_VEC    = 8'h0F;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iInt = 1'b0;
  logic        iIntEn = 1'b0;
  logic        iBoundary = 1'b0;
  logic        iSel = 1'b0;
  logic [7:0]  iData = 8'h00;
  logic        iBusRdy = 1'b0;
  logic [7:0]  iBusData = 8'h00;
  logic        oIntAck;
  logic        oBusRd;
  logic [19:0] oBusAddr;
  logic        oDone;
  logic [7:0]  oVector;
  logic [15:0] oIp;
  logic [15:0] oCs;
  logic        oSpurious;
  logic        oBusy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] mem [0:1023];

  always #5 iClk = ~iClk;

  int_ack_sequencer #(
    .ACK_GAP      (ACK_GAP),
    .SEL_TIMEOUT  (SEL_TIMEOUT),
    .SPURIOUS_VEC (SPUR_VEC)
  ) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iInt      (iInt),
    .iIntEn    (iIntEn),
    .iBoundary (iBoundary),
    .oIntAck   (oIntAck),
    .iSel      (iSel),
    .iData     (iData),
    .oBusRd    (oBusRd),
    .oBusAddr  (oBusAddr),
    .iBusRdy   (iBusRdy),
    .iBusData  (iBusData),
    .oDone     (oDone),
    .oVector   (oVector),
    .oIp       (oIp),
    .oCs       (oCs),
    .oSpurious (oSpurious),
    .oBusy     (oBusy)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {31'd0, oIntAck, oBusRd, oBusAddr, oDone, oVector, oIp, oCs, oSpurious, oBusy};
  endfunction

  // One full acknowledge sequence. d: WAIT_VEC cycle index at which the PIC answers
  // (d >= SEL_TIMEOUT means it never answers in time); d0..d3: extra wait cycles per bus byte.
  task automatic run_txn(input string name, input int d, input logic [7:0] pic_vec,
                         input int d0, input int d1, input int d2, input int d3,
                         input bit drop_int);
    int dly [4];
    int w0, f, total, done_exp, spur_exp, base;
    bit spur;
    logic [7:0] vexp;
    logic [15:0] ip_exp, cs_exp;
    int t, spur_t, done_t, byte_i, waited, unstable, busy_bad;
    bit req_on;
    logic [19:0] req_addr;
    int acks [$];
    logic [19:0] addrs [$];
    logic [7:0] got_vec;
    logic [15:0] got_ip, got_cs;

    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    // Reference timeline: trigger sampled in interval 0, everything else counted from there.
    w0       = 3 + ACK_GAP;
    spur     = (d >= SEL_TIMEOUT);
    vexp     = spur ? SPUR_VEC : pic_vec;
    f        = w0 + (spur ? SEL_TIMEOUT - 1 : d) + 1;
    total    = 0;
    for (int k = 0; k < 4; k++) total += dly[k] + 1;
    done_exp = f + total + 1;
    spur_exp = spur ? w0 + SEL_TIMEOUT : -1;
    base     = int'(vexp) * 4;
    ip_exp   = {mem[base + 1], mem[base]};
    cs_exp   = {mem[base + 3], mem[base + 2]};

    t = 0; spur_t = -1; done_t = -1; byte_i = 0; waited = 0; unstable = 0; busy_bad = 0;
    req_on = 1'b0; req_addr = '0; got_vec = '0; got_ip = '0; got_cs = '0;

    @(negedge iClk);
    iBoundary = 1'b1; iInt = 1'b1; iIntEn = 1'b1;
    while (done_t < 0 && t < 100) begin
      @(negedge iClk);
      t++;
      iBoundary = 1'b0; iSel = 1'b0; iBusRdy = 1'b0;
      if (drop_int && t == 2) iInt = 1'b0;
      if (oIntAck) acks.push_back(t);
      if (oSpurious) spur_t = t;
      if (!oBusy) busy_bad++;
      if (oBusRd) begin
        if (!req_on) begin
          req_on = 1'b1; req_addr = oBusAddr; waited = 0;
        end else if (oBusAddr !== req_addr) begin
          unstable++;
        end
        if (waited >= dly[byte_i % 4]) begin
          iBusRdy = 1'b1;
          iBusData = mem[oBusAddr[9:0]];
          addrs.push_back(oBusAddr);
          byte_i++;
          req_on = 1'b0;
        end else begin
          waited++;
        end
      end
      if (oDone) begin
        done_t = t; got_vec = oVector; got_ip = oIp; got_cs = oCs;
      end
      if (t == w0 + d) begin
        iSel = 1'b1; iData = pic_vec;
      end
    end

    chk({name, ":completed"}, done_t >= 0, 1);
    chk({name, ":done_t"}, done_t, done_exp);
    chk({name, ":ack_n"}, acks.size(), 2);
    if (acks.size() >= 2) begin
      chk({name, ":ack1_t"}, acks[0], 1);
      chk({name, ":ack2_t"}, acks[1], 2 + ACK_GAP);
    end
    chk({name, ":spur_t"}, spur_t, spur_exp);
    chk({name, ":rd_n"}, addrs.size(), 4);
    for (int k = 0; k < 4 && k < addrs.size(); k++)
      chk({name, ":rd_addr"}, addrs[k], 20'(base + k));
    chk({name, ":addr_stable"}, unstable, 0);
    chk({name, ":busy"}, busy_bad, 0);
    chk({name, ":vec"}, got_vec, vexp);
    chk({name, ":ip"}, got_ip, ip_exp);
    chk({name, ":cs"}, got_cs, cs_exp);

    @(negedge iClk);
    iSel = 1'b0; iBusRdy = 1'b0; iBoundary = 1'b0;
    chk({name, ":post_done_busy"}, {oDone, oBusy, oBusRd}, 3'b000);
    chk({name, ":hold"}, {oVector, oIp, oCs}, {vexp, ip_exp, cs_exp});
  endtask

  initial begin
    bit hit;
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[20'h20] = 8'h34; mem[20'h21] = 8'h12; mem[20'h22] = 8'h00; mem[20'h23] = 8'hF0;

    repeat (3) @(negedge iClk);
    chk("reset_outs", all_outs(), '0);
    iRstN = 1'b1;
    @(negedge iClk);
    chk("idle_outs", all_outs(), '0);

    run_txn("t1_ideal", 0, 8'h08, 0, 0, 0, 0, 1'b0);
    run_txn("t2_timeout", SEL_TIMEOUT + 3, 8'h55, 0, 0, 0, 0, 1'b0);
    run_txn("t3_coincide", SEL_TIMEOUT - 1, 8'h09, 0, 0, 0, 0, 1'b0);

    // Trigger masked by IF, and a stray PIC response while idle.
    iInt = 1'b1; iIntEn = 1'b0; iBoundary = 1'b1;
    @(negedge iClk);
    iBoundary = 1'b0; iSel = 1'b1; iData = 8'h55;
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge iClk);
      iSel = 1'b0;
      if (oIntAck || oBusy || oBusRd || oDone) hit = 1'b1;
    end
    chk("t4_masked_idle", hit, 1'b0);
    chk("t4_vec_held", oVector, 8'h09);

    run_txn("t5_slow_bus", 0, 8'h08, 3, 3, 3, 3, 1'b0);

    // Reset in the middle of the IVT fetch, right as byte 2 is being requested.
    @(negedge iClk);
    iBoundary = 1'b1; iInt = 1'b1; iIntEn = 1'b1;
    hit = 1'b0;
    t = 0;
    while (!hit && t < 40) begin
      @(negedge iClk);
      t++;
      iBoundary = 1'b0; iSel = 1'b0; iBusRdy = 1'b0;
      if (oBusRd && oBusAddr[1:0] == 2'd2) begin
        hit = 1'b1;
      end else begin
        if (oBusRd) begin
          iBusRdy = 1'b1; iBusData = mem[oBusAddr[9:0]];
        end
        if (t == 3 + ACK_GAP) begin
          iSel = 1'b1; iData = 8'h08;
        end
      end
    end
    chk("t6_reached_k2", hit, 1'b1);
    #1 iRstN = 1'b0;
    #1 chk("t6_async_rst", all_outs(), '0);
    @(negedge iClk);
    chk("t6_rst_held", all_outs(), '0);
    iRstN = 1'b1;
    @(negedge iClk);
    chk("t6_after_rst", all_outs(), '0);
    run_txn("t6_rerun", 0, 8'h08, 0, 0, 0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int gap;
      run_txn("rnd", int'($urandom_range(0, SEL_TIMEOUT + 3)), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge iClk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
